grey_run_ctrl: RTL

//   Sequencer for the 12-digit grey-coded decade counter datapath.
//   - Serially assembles the 60-bit preset word and issues a one-cycle load strobe.
//   - Gates counting with a programmable prescaled count-enable tick.
//   - Free-runs a digit-scan index that drives the counter's readout select.

---
 rtl/grey_run_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/grey_run_ctrl.sv
// rtl/grey_run_ctrl.sv - preset shifter, load strobe, prescaled count-enable and digit-scan sequencer
// Defining GREY_RUN_CTRL_STEP_EN adds the single-step input.
module grey_run_ctrl #(
  parameter int NDIG      = 12,
  parameter int DW        = 5,
  parameter int SCAN_LOG2 = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ser_din,
  input  logic                 sh_en,
  input  logic                 load_go,
  input  logic                 run,
`ifdef GREY_RUN_CTRL_STEP_EN
  input  logic                 step,
`endif
  input  logic [3:0]           rate,
  output logic [NDIG*DW-1:0]   init,
  output logic                 load,
  output logic                 cnt_en,
  output logic [5:0]           sel,
  output logic                 busy,
  output logic                 err
);

  localparam int NBITS = NDIG * DW;
  localparam int BCW   = $clog2(NBITS + 1);
  localparam logic [BCW-1:0] FULL     = BCW'(NBITS);
  localparam logic [5:0]     SEL_LAST = 6'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t            state, state_d;
  logic [NBITS-1:0]  init_d;
  logic [BCW-1:0]    bitcnt, bitcnt_d;
  logic [15:0]       presc, presc_d;
  logic [3:0]        rate_q, rate_d;
  logic              load_d, cnt_en_d, busy_d, err_d;
  logic              presc_wrap;
  logic              step_rise;
  logic [SCAN_LOG2-1:0] scan_div;

  // rate_q is the period in force; a new rate is only adopted at a wrap
  assign presc_wrap = (presc == ((16'd1 << rate_q) - 16'd1));

`ifdef GREY_RUN_CTRL_STEP_EN
  logic step_q;

  always_ff @(posedge CLK) begin
    if (!RST) step_q <= 1'b0;
    else      step_q <= step;
  end

  assign step_rise = step & ~step_q;
`else
  assign step_rise = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    init_d   = init;
    bitcnt_d = bitcnt;
    presc_d  = presc;
    rate_d   = rate_q;
    load_d   = 1'b0;
    cnt_en_d = 1'b0;
    err_d    = err;
    busy_d   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_en_d = step_rise;
        // a shift strobe wins over a simultaneous load request
        if (sh_en) begin
          init_d = {init[NBITS-2:0], ser_din};
          if (bitcnt != FULL) bitcnt_d = bitcnt + BCW'(1);
        end else if (load_go) begin
          if (bitcnt == FULL) begin
            state_d = S_LOAD;
            load_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        bitcnt_d = '0;
        presc_d  = '0;
        rate_d   = rate;
        state_d  = run ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (presc_wrap) begin
          presc_d  = '0;
          cnt_en_d = 1'b1;
          rate_d   = rate;
        end else begin
          presc_d = presc + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= S_IDLE;
      init   <= '0;
      bitcnt <= '0;
      presc  <= '0;
      rate_q <= '0;
      load   <= 1'b0;
      cnt_en <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      init   <= init_d;
      bitcnt <= bitcnt_d;
      presc  <= presc_d;
      rate_q <= rate_d;
      load   <= load_d;
      cnt_en <= cnt_en_d;
      busy   <= busy_d;
      err    <= err_d;
    end
  end

  // readout scan runs regardless of sequencer state
  always_ff @(posedge CLK) begin
    if (!RST) begin
      scan_div <= '0;
      sel      <= '0;
    end else begin
      scan_div <= scan_div + SCAN_LOG2'(1);
      if (&scan_div) sel <= (sel == SEL_LAST) ? 6'd0 : sel + 6'd1;
    end
  end

endmodule
